// File: rtl/seg_to_hex_decoder_pkg.sv
// Seven-segment pattern constants, FSM states and pattern-to-nibble decode,
// shared by the decoder and the display encoder. Segments are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_C     = 7'b100_0110;
  localparam logic [6:0] SEG_D     = 7'b010_0001;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_F     = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // legal covers both digits and blank; nibble is meaningful only for digits
  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t r;
    r = '{legal: 1'b1, is_blank: 1'b0, nibble: 4'h0};
    case (pat)
      SEG_0:     r.nibble = 4'h0;
      SEG_1:     r.nibble = 4'h1;
      SEG_2:     r.nibble = 4'h2;
      SEG_3:     r.nibble = 4'h3;
      SEG_4:     r.nibble = 4'h4;
      SEG_5:     r.nibble = 4'h5;
      SEG_6:     r.nibble = 4'h6;
      SEG_7:     r.nibble = 4'h7;
      SEG_8:     r.nibble = 4'h8;
      SEG_9:     r.nibble = 4'h9;
      SEG_A:     r.nibble = 4'hA;
      SEG_B:     r.nibble = 4'hB;
      SEG_C:     r.nibble = 4'hC;
      SEG_D:     r.nibble = 4'hD;
      SEG_E:     r.nibble = 4'hE;
      SEG_F:     r.nibble = 4'hF;
      SEG_BLANK: r.is_blank = 1'b1;
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_to_hex_decoder_if.sv
// Segment-bus input and decoded-digit output bundle for seg_to_hex_decoder.
// master drives the segment bus and clear; slave is the decoder.
interface seg_to_hex_decoder_if;
  logic [6:0] seg_in;
  logic       clear_err;
  logic [3:0] data;
  logic       data_valid;
  logic       blank;
  logic       error;
  logic [7:0] err_count;
  logic       locked;

  modport master (
    output seg_in, clear_err,
    input  data, data_valid, blank, error, err_count, locked
  );

  modport slave (
    input  seg_in, clear_err,
    output data, data_valid, blank, error, err_count, locked
  );
endinterface

// File: rtl/seg_to_hex_decoder_sync.sv
// Two-flop synchronizer for a multi-bit quasi-static bus; 2-cycle latency.
// Bits may resolve on different cycles; the downstream stability filter absorbs that.
module seg_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/seg_to_hex_decoder.sv
// Debounces an asynchronous 7-segment bus and decodes it to a hex nibble; no backpressure.
// Latency STABLE_CYCLES+2 from first sampling edge of a steady pattern to the data_valid pulse.
module seg_to_hex_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  seg_to_hex_decoder_if.slave   bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_s;
  logic [6:0] prev_q;
  logic [7:0] cnt_q;
  state_t     state_q, state_d;
  logic       match;
  logic       accept;
  logic       locked_o;
  logic       new_pat;
  seg_dec_t   dec;

  logic [6:0] acc_q;
  logic [3:0] data_q;
  logic       dv_q;
  logic       blank_q;
  logic       err_q;
  logic [7:0] errcnt_q;

  seg_sync #(.W(7), .RST_VAL(SEG_BLANK)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.seg_in),
    .q     (seg_s)
  );

  assign match = (seg_s == prev_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= SEG_BLANK;
      cnt_q  <= 8'd0;
    end else begin
      prev_q <= seg_s;
      if (!match)
        cnt_q <= 8'd0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= SETTLING;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLING: if (match && cnt_q == CNT_MAX) state_d = LOCKED;
      LOCKED:   if (!match)                    state_d = SETTLING;
      default:                                 state_d = SETTLING;
    endcase
  end

  always_comb begin
    accept   = (state_q == SETTLING) && match && (cnt_q == CNT_MAX);
    locked_o = (state_q == LOCKED);
  end

  // a glitch that settles back onto the accepted pattern must stay invisible
  assign new_pat = accept && (seg_s != acc_q);
  assign dec     = seg_decode(seg_s);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q    <= SEG_BLANK;
      data_q   <= 4'h0;
      dv_q     <= 1'b0;
      blank_q  <= 1'b1;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      dv_q <= new_pat;
      if (new_pat) begin
        acc_q <= seg_s;
        if (!dec.legal) begin
          err_q   <= 1'b1;
          blank_q <= 1'b0;
        end else if (dec.is_blank) begin
          err_q   <= 1'b0;
          blank_q <= 1'b1;
        end else begin
          err_q   <= 1'b0;
          blank_q <= 1'b0;
          data_q  <= dec.nibble;
        end
      end
      if (bus.clear_err)
        errcnt_q <= 8'd0;
      else if (new_pat && !dec.legal && errcnt_q != 8'hFF)
        errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.blank      = blank_q;
  assign bus.error      = err_q;
  assign bus.err_count  = errcnt_q;
  assign bus.locked     = locked_o;

endmodule

// File: tb/tb_seg_to_hex_decoder.sv
// Self-checking bench: random and directed segment patterns against a run-length reference model.
module tb_seg_to_hex_decoder;

  localparam int S = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;

  seg_to_hex_decoder_if bus();

  seg_to_hex_decoder #(.STABLE_CYCLES(S)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [6:0] hex_tab [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

  typedef struct packed {
    logic       dv;
    logic [3:0] data;
    logic       blank;
    logic       error;
    logic       inc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // reference model: outputs appear two edges after the run of equal samples reaches S+1
  exp_t       q [$];
  int         run, run_p1, m_err, dv_seen;
  logic [6:0] lastv, last_acc;
  logic [3:0] m_data;
  logic       m_blank, m_error;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (hex_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    exp_t r;
    r = '{dv: 1'b0, data: 4'h0, blank: 1'b1, error: 1'b0, inc: 1'b0};
    q.delete();
    q.push_back(r);
    q.push_back(r);
    run      = 3;
    run_p1   = 2;
    lastv    = 7'h7F;
    last_acc = 7'h7F;
    m_data   = 4'h0;
    m_blank  = 1'b1;
    m_error  = 1'b0;
    m_err    = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    chk("rst_data",   int'(bus.data), 0);
    chk("rst_dv",     int'(bus.data_valid), 0);
    chk("rst_blank",  int'(bus.blank), 1);
    chk("rst_error",  int'(bus.error), 0);
    chk("rst_errcnt", int'(bus.err_count), 0);
    chk("rst_locked", int'(bus.locked), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [6:0] seg, input logic clr);
    exp_t r;
    int   r2, idx;
    bus.seg_in    = seg;
    bus.clear_err = clr;
    @(posedge clock);
    r2     = run_p1;
    run_p1 = run;
    if (seg == lastv) run++;
    else begin
      run   = 1;
      lastv = seg;
    end
    r = '{dv: 1'b0, data: m_data, blank: m_blank, error: m_error, inc: 1'b0};
    if (run == S + 1 && seg != last_acc) begin
      last_acc = seg;
      idx      = lookup(seg);
      r.dv     = 1'b1;
      if (idx >= 0) begin
        m_data  = 4'(idx);
        m_blank = 1'b0;
        m_error = 1'b0;
      end else if (seg == 7'h7F) begin
        m_blank = 1'b1;
        m_error = 1'b0;
      end else begin
        m_blank = 1'b0;
        m_error = 1'b1;
        r.inc   = 1'b1;
      end
      r.data  = m_data;
      r.blank = m_blank;
      r.error = m_error;
    end
    q.push_back(r);
    r = q.pop_front();
    if (clr) m_err = 0;
    else if (r.inc && m_err < 255) m_err++;
    #1;
    chk("dv",     int'(bus.data_valid), int'(r.dv));
    chk("data",   int'(bus.data), int'(r.data));
    chk("blank",  int'(bus.blank), int'(r.blank));
    chk("error",  int'(bus.error), int'(r.error));
    chk("errcnt", int'(bus.err_count), m_err);
    chk("locked", int'(bus.locked), (r2 >= S + 1) ? 1 : 0);
    if (bus.data_valid) dv_seen++;
  endtask

  task automatic measure(input logic [6:0] seg, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      step(seg, 1'b0);
      if (bus.data_valid && lat < 0) lat = i;
    end
  endtask

  initial begin
    int lat, d0, hold, sel;
    logic [6:0] p;
    bus.seg_in    = 7'h7F;
    bus.clear_err = 1'b0;
    dv_seen       = 0;
    #1;
    apply_reset();

    // steady blank after reset settles silently
    repeat (30) step(7'h7F, 1'b0);
    chk("blank_settle_dv", dv_seen, 0);

    measure(7'b011_0000, lat);
    chk("lat_3", lat, S + 2);
    chk("d3_data", int'(bus.data), 3);
    chk("d3_blank", int'(bus.blank), 0);
    chk("d3_error", int'(bus.error), 0);
    chk("d3_locked", int'(bus.locked), 1);

    // short excursion returning to the same digit
    d0 = dv_seen;
    repeat (10) step(7'b000_1000, 1'b0);
    repeat (30) step(7'b011_0000, 1'b0);
    chk("glitch_dv", dv_seen - d0, 0);
    chk("glitch_data", int'(bus.data), 3);

    d0 = dv_seen;
    repeat (30) step(7'b101_0101, 1'b0);
    chk("ill_dv", dv_seen - d0, 1);
    chk("ill_error", int'(bus.error), 1);
    chk("ill_errcnt", int'(bus.err_count), 1);
    chk("ill_data", int'(bus.data), 3);

    for (int i = 0; i < 256; i++)
      repeat (20) step((i % 2 == 0) ? 7'b110_1101 : 7'b101_0101, 1'b0);
    chk("err_sat", int'(bus.err_count), 255);

    // clear lands on the same edge as the acceptance increment
    for (int i = 0; i <= S + 2; i++)
      step(7'b110_1101, (i == S + 2) ? 1'b1 : 1'b0);
    chk("clr_dv", int'(bus.data_valid), 1);
    chk("clr_errcnt", int'(bus.err_count), 0);
    chk("clr_error", int'(bus.error), 1);
    repeat (5) step(7'b110_1101, 1'b0);

    d0 = dv_seen;
    for (int i = 0; i < 17; i++) begin
      p = (i < 16) ? hex_tab[i] : 7'h7F;
      repeat (20) step(p, 1'b0);
      chk("sweep_blank", int'(bus.blank), (i == 16) ? 1 : 0);
      if (i < 16) chk("sweep_data", int'(bus.data), i);
    end
    chk("sweep_pulses", dv_seen - d0, 17);

    for (int n = 0; n < 200; n++) begin
      sel  = int'($urandom_range(0, 20));
      if (sel > 16) p = 7'($urandom_range(0, 127));
      else if (sel == 16) p = 7'h7F;
      else p = hex_tab[sel];
      hold = int'($urandom_range(1, 24));
      repeat (hold) step(p, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    // reset in the middle of settling on F discards the partial count
    repeat (8) step(7'b000_1110, 1'b0);
    apply_reset();
    measure(7'b000_1110, lat);
    chk("lat_f", lat, S + 2);
    chk("f_data", int'(bus.data), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_to_hex_decoder.md
SEG_TO_HEX_DECODER -- requirements
Module: seg_to_hex_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 The parameter STABLE_CYCLES SHALL default to 16 and set the consecutive identical synchronized samples needed to accept a pattern; legal range is 2..255.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 seg_in  input  7  active-low segment bus {g,f,e,d,c,b,a}, asynchronous to clock.
REQ-006 clear_err  input  1  synchronous clear of err_count.
REQ-007 data  output  4  last accepted valid hex digit.
REQ-008 data_valid  output  1  one-cycle pulse on each newly accepted pattern.
REQ-009 blank  output  1  high while the last accepted pattern is 7'b111_1111.
REQ-010 error  output  1  high while the last accepted pattern is not a legal digit or blank.
REQ-011 err_count  output  8  saturating count of accepted illegal patterns.
REQ-012 locked  output  1  high in state LOCKED.

Function
REQ-013 seg_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Legal patterns SHALL be: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110, blank=111_1111.
REQ-015 FSM states SHALL be SETTLING and LOCKED.
REQ-016 Each cycle, the synchronized sample SHALL be compared with the previous cycle's sample; on a mismatch the stability counter clears to 0 and the state goes to SETTLING.
REQ-017 On a match, the counter SHALL increment, saturating at STABLE_CYCLES-1.
REQ-018 In SETTLING, when the counter reaches STABLE_CYCLES-1 with a match, the pattern SHALL be accepted and the state SHALL go to LOCKED.
REQ-019 LOCKED SHALL hold, with no further acceptances, until a sample mismatch occurs.
REQ-020 On acceptance, data_valid SHALL pulse high for exactly one cycle, registered, in the cycle after the acceptance condition is met.
REQ-021 On acceptance of a pattern that equals the previously accepted pattern (a glitch that returned to the same value), no data_valid pulse SHALL be issued and no output SHALL change.
REQ-022 Accepted legal digit: data = the digit value, blank = 0, error = 0.
REQ-023 Accepted blank: blank = 1, error = 0, data holds.
REQ-024 Accepted illegal pattern: error = 1, blank = 0, data holds, err_count increments by 1 and saturates at 255.
REQ-025 Latency SHALL be STABLE_CYCLES+2 cycles from the first edge sampling a new, steady seg_in value to the data_valid pulse.
REQ-026 A seg_in change lasting fewer than STABLE_CYCLES synchronized cycles SHALL NOT be accepted.
REQ-027 clear_err SHALL zero err_count on the next edge, and SHALL take priority over a same-cycle increment (the increment is lost).
REQ-028 clear_err SHALL NOT affect error or any other output.

Reset
REQ-029 Reset SHALL immediately force: synchronizer flops and the last accepted pattern = 111_1111; counter = 0; state = SETTLING; data = 0; data_valid = 0; blank = 1; error = 0; err_count = 0; locked = 0.
REQ-030 Reset asserted mid-settling SHALL discard the partial count; after release the full STABLE_CYCLES+2 latency applies again.
REQ-031 After reset release with seg_in steady at blank, a full settle SHALL occur with no data_valid pulse, because the accepted pattern equals the reset pattern.

Structure
REQ-032 Package seg_pkg SHALL hold the 17 segment constants, the state enumeration and the pattern-to-nibble decode function, shared with the display encoder.
REQ-033 The 2-flop synchronizer SHALL be a separate sub-module, seg_sync, parameterized by width.

Verification
REQ-034 Reset, then hold seg_in=011_0000 -> data_valid pulses once at cycle 18 (STABLE_CYCLES=16); data=3, blank=0, error=0, locked=1.
REQ-035 From locked 3, drive seg_in=000_1000 for 10 cycles, then back to 011_0000 -> no data_valid; data stays 3.
REQ-036 Drive seg_in=101_0101 steadily -> one data_valid pulse; error=1; err_count=1; data holds its previous value.
REQ-037 Alternate 256 times between illegal 101_0101 and illegal 110_1101, each held steady for 20 cycles -> err_count saturates at 255; assert clear_err in the same cycle as an acceptance -> err_count=0.
REQ-038 Assert reset at cycle 8 of settling on 000_1110 -> all outputs at reset values; after release, data_valid asserts 18 cycles later with data=F.
REQ-039 Sweep all 16 digit patterns plus blank, each held steady for 20 cycles -> one pulse per pattern, data equals the digit, and blank is set only for 111_1111.
